// File: rtl/btrain_update.sv
// -----------------------------------------------------------------------------
// btrain_update
//
// Perceptron training stage that sits directly in front of the branch weight
// tables. Branch-resolution records from execute are buffered in a small FIFO.
// Each popped record is checked against its prediction-time output and the
// training threshold. Records that need training get their 8-weight row
// updated one lane per cycle with saturating +/-1 steps. The finished row and
// its index are then presented together with a single-cycle write strobe.
//
// Parameters
//   THETA        training threshold; train when mispredicted or |sum| <= THETA
//   FIFO_DEPTH   resolution-record buffer depth (power of two)
//
// Ports
//   i_clk                clock, all state on the rising edge
//   i_rst_n              asynchronous active-low reset
//   i_resValid           resolution record valid
//   o_resReady           FIFO not full (taken from the registered count)
//   i_resIdx_8           weight-row index, 0..227
//   i_resHist_8          history bits at prediction (1 -> x=+1, 0 -> x=-1)
//   i_resSum_12          signed perceptron output at prediction
//   i_resTaken           actual branch outcome
//   i_weightTable_16416  flattened table, row r at [r*72 +: 72], 9-bit weights
//   o_fire               one-cycle table write strobe
//   o_errWeightPos_8     row index being written (held until the next write)
//   o_newWeights_72      updated row (held until the next write)
//   o_busy               FSM not idle or FIFO non-empty
//   o_trainCount_16      saturating count of issued writes
//
// Build option
//   BTRAIN_FWD_EN  When defined, the SETTLE cycle is removed. A record whose
//                  index matches the last written row takes its row from
//                  o_newWeights_72 rather than from the table bus.
// -----------------------------------------------------------------------------

module btrain_update #(
    parameter int          THETA      = 29,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_resValid,
    output logic           o_resReady,
    input  logic [7:0]     i_resIdx_8,
    input  logic [7:0]     i_resHist_8,
    input  logic [11:0]    i_resSum_12,
    input  logic           i_resTaken,
    input  logic [16415:0] i_weightTable_16416,
    output logic           o_fire,
    output logic [7:0]     o_errWeightPos_8,
    output logic [71:0]    o_newWeights_72,
    output logic           o_busy,
    output logic [15:0]    o_trainCount_16
);

`ifdef BTRAIN_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned RecW    = 29;   // {taken, sum[11:0], hist[7:0], idx[7:0]}
    localparam logic [7:0]  NumRows = 8'd228;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLane,
        StFire,
        StSettle
    } state_e;

    // -------------------------------------------------------------------------
    // Resolution-record FIFO
    // -------------------------------------------------------------------------
    logic [RecW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic [RecW-1:0] fifo_rd;
    logic            push;
    logic            pop;

    state_e          state_q;

    // Ready comes from the registered count, so a full FIFO refuses a push
    // even in a cycle where the FSM pops.
    assign o_resReady = (cnt_q != CntW'(FIFO_DEPTH));
    assign push       = i_resValid && o_resReady;
    assign pop        = (state_q == StIdle) && (cnt_q != '0);
    assign fifo_rd    = fifo_mem[rd_ptr_q];

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {i_resTaken, i_resSum_12, i_resHist_8, i_resIdx_8};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Latched record and working row
    // -------------------------------------------------------------------------
    logic [7:0]  rec_idx_q;
    logic [7:0]  rec_hist_q;
    logic [11:0] rec_sum_q;
    logic        rec_taken_q;
    logic [71:0] row_q;
    logic [2:0]  lane_q;

    // -------------------------------------------------------------------------
    // LOAD-cycle decision
    // -------------------------------------------------------------------------
    logic        idx_ok;
    logic [7:0]  row_sel;
    logic [14:0] row_base;
    logic [71:0] table_row;
    logic        fwd_hit;
    logic [71:0] load_row;
    logic [11:0] sum_mag;
    logic        pred_taken;
    logic        need_train;

    assign idx_ok = (rec_idx_q < NumRows);

    // Out-of-range records are dropped anyway. Steering them to row 0 keeps
    // the part-select inside the bus.
    assign row_sel   = idx_ok ? rec_idx_q : 8'd0;
    assign row_base  = 15'(row_sel) * 15'd72;
    assign table_row = i_weightTable_16416[row_base +: 72];

    // The held output row is only trusted once at least one write has been
    // issued. The count saturates and never returns to zero, so it works as
    // the "written since reset" flag.
    assign fwd_hit  = FwdEn && (rec_idx_q == o_errWeightPos_8) && (o_trainCount_16 != 16'd0);
    assign load_row = fwd_hit ? o_newWeights_72 : table_row;

    // |sum| taken as an unsigned 12-bit value, so -2048 maps to 2048.
    assign sum_mag    = rec_sum_q[11] ? (~rec_sum_q + 12'd1) : rec_sum_q;
    assign pred_taken = ~rec_sum_q[11];
    assign need_train = (pred_taken != rec_taken_q) || (sum_mag <= 12'(THETA));

    // -------------------------------------------------------------------------
    // Per-lane saturating update
    // -------------------------------------------------------------------------
    function automatic logic [8:0] sat_step(input logic [8:0] w, input logic up);
        logic [8:0] r;
        if (up) begin
            r = (w == 9'h0FF) ? w : (w + 9'd1);    // ceiling +255
        end else begin
            r = (w == 9'h100) ? w : (w - 9'd1);    // floor -256
        end
        return r;
    endfunction

    logic [71:0] lane_row;

    always_comb begin
        lane_row = row_q;
        for (int j = 0; j < 8; j++) begin
            if (lane_q == 3'(j)) begin
                // x*t = +1 exactly when the history bit matches the outcome.
                lane_row[j*9 +: 9] = sat_step(row_q[j*9 +: 9], rec_hist_q[j] == rec_taken_q);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= StIdle;
            lane_q           <= 3'd0;
            rec_idx_q        <= 8'd0;
            rec_hist_q       <= 8'd0;
            rec_sum_q        <= 12'd0;
            rec_taken_q      <= 1'b0;
            row_q            <= 72'd0;
            o_fire           <= 1'b0;
            o_errWeightPos_8 <= 8'd0;
            o_newWeights_72  <= 72'd0;
            o_trainCount_16  <= 16'd0;
        end else begin
            o_fire <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        rec_idx_q   <= fifo_rd[7:0];
                        rec_hist_q  <= fifo_rd[15:8];
                        rec_sum_q   <= fifo_rd[27:16];
                        rec_taken_q <= fifo_rd[28];
                        state_q     <= StLoad;
                    end
                end
                StLoad: begin
                    if (idx_ok && need_train) begin
                        row_q   <= load_row;
                        lane_q  <= 3'd0;
                        state_q <= StLane;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StLane: begin
                    row_q  <= lane_row;
                    lane_q <= lane_q + 3'd1;
                    if (lane_q == 3'd7) begin
                        // The outputs change only here, so an update cut short
                        // by reset never reaches the table.
                        state_q          <= StFire;
                        o_fire           <= 1'b1;
                        o_errWeightPos_8 <= rec_idx_q;
                        o_newWeights_72  <= lane_row;
                        if (o_trainCount_16 != 16'hFFFF) begin
                            o_trainCount_16 <= o_trainCount_16 + 16'd1;
                        end
                    end
                end
                StFire: begin
                    // SETTLE gives the table one cycle to show the new row
                    // before another LOAD; forwarding makes it unnecessary.
                    state_q <= FwdEn ? StIdle : StSettle;
                end
                StSettle: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_busy = (state_q != StIdle) || (cnt_q != '0);

endmodule

// File: tb/tb_btrain_update.sv
module tb_btrain_update;

`ifdef BTRAIN_FWD_EN
    localparam int Spacing = 11;
`else
    localparam int Spacing = 12;
`endif

    logic           clk;
    logic           rst_n;
    logic           res_valid;
    logic           res_ready;
    logic [7:0]     res_idx;
    logic [7:0]     res_hist;
    logic [11:0]    res_sum;
    logic           res_taken;
    logic [16415:0] tbl = '0;
    logic           fire;
    logic [7:0]     pos;
    logic [71:0]    new_w;
    logic           busy;
    logic [15:0]    train_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nfires = 0;
    int          fire_cyc [64];
    logic [7:0]  fire_pos [64];
    logic [71:0] fire_w   [64];

    logic        set_req = 1'b0;
    logic [7:0]  set_idx = 8'd0;
    logic [71:0] set_val = 72'd0;

    btrain_update #(
        .THETA      (29),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_resValid          (res_valid),
        .o_resReady          (res_ready),
        .i_resIdx_8          (res_idx),
        .i_resHist_8         (res_hist),
        .i_resSum_12         (res_sum),
        .i_resTaken          (res_taken),
        .i_weightTable_16416 (tbl),
        .o_fire              (fire),
        .o_errWeightPos_8    (pos),
        .o_newWeights_72     (new_w),
        .o_busy              (busy),
        .o_trainCount_16     (train_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Weight-table model plus fire log; the table takes the write on o_fire.
    always @(posedge clk) begin
        if (fire) begin
            if (nfires < 64) begin
                fire_cyc[nfires] <= cyc;
                fire_pos[nfires] <= pos;
                fire_w[nfires]   <= new_w;
            end
            nfires <= nfires + 1;
            tbl[int'(pos)*72 +: 72] <= new_w;
        end else if (set_req) begin
            tbl[int'(set_idx)*72 +: 72] <= set_val;
        end
        cyc <= cyc + 1;
    end

    function automatic logic [71:0] mk_row(input logic [8:0] w0, input logic [8:0] w1,
                                           input logic [8:0] w2, input logic [8:0] w3,
                                           input logic [8:0] w4, input logic [8:0] w5,
                                           input logic [8:0] w6, input logic [8:0] w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input logic [7:0] idx, input logic [71:0] val);
        set_idx = idx;
        set_val = val;
        set_req = 1'b1;
        step();
        set_req = 1'b0;
    endtask

    task automatic push_rec(input logic [7:0] idx, input logic [7:0] hist,
                            input logic [11:0] sum, input logic taken, output int acc);
        bit done;
        done      = 1'b0;
        acc       = -1;
        res_idx   = idx;
        res_hist  = hist;
        res_sum   = sum;
        res_taken = taken;
        res_valid = 1'b1;
        for (int i = 0; i < 80 && !done; i++) begin
            if (res_ready === 1'b1) begin
                acc  = cyc;
                done = 1'b1;
            end
            step();
        end
        res_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout idx=%0d ready=%b required 1", idx, res_ready);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            step();
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout busy=%b required 0", busy);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        res_valid = 1'b0;
        res_idx   = 8'd0;
        res_hist  = 8'd0;
        res_sum   = 12'd0;
        res_taken = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        checks++; if (fire !== 1'b0) begin errors++; $display("FAIL rst_fire got %b want 0", fire); end
        checks++; if (pos !== 8'd0) begin errors++; $display("FAIL rst_pos got %0d want 0", pos); end
        checks++; if (new_w !== 72'd0) begin errors++; $display("FAIL rst_w got %h want 0", new_w); end
        checks++; if (train_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", train_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", res_ready); end
    endtask

    task automatic test_mispredict();
        int acc, base;
        base = nfires;
        push_rec(8'd5, 8'hF0, 12'd10, 1'b0, acc);
        wait_idle();
        checks++; if (nfires - base !== 1) begin errors++; $display("FAIL mis_nfire got %0d want 1", nfires - base); end
        checks++; if (fire_cyc[base] - acc !== 11) begin errors++; $display("FAIL mis_lat got %0d want 11", fire_cyc[base] - acc); end
        checks++; if (pos !== 8'd5) begin errors++; $display("FAIL mis_pos got %0d want 5", pos); end
        checks++;
        if (new_w !== mk_row(9'h001, 9'h001, 9'h001, 9'h001, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF)) begin
            errors++; $display("FAIL mis_w got %h want 1ff..001 pattern", new_w);
        end
        checks++; if (train_cnt !== 16'd1) begin errors++; $display("FAIL mis_cnt got %0d want 1", train_cnt); end
    endtask

    task automatic test_confident();
        int acc, base;
        base = nfires;
        push_rec(8'd6, 8'hAA, 12'd40, 1'b1, acc);          // confident & correct: skip
        wait_idle();
        checks++; if (nfires !== base) begin errors++; $display("FAIL conf40_fire got %0d want 0", nfires - base); end
        checks++; if (train_cnt !== 16'd1) begin errors++; $display("FAIL conf40_cnt got %0d want 1", train_cnt); end
        push_rec(8'd6, 8'h00, 12'h800, 1'b0, acc);         // -2048, correct: skip
        wait_idle();
        checks++; if (nfires !== base) begin errors++; $display("FAIL conf2048_fire got %0d want 0", nfires - base); end
        push_rec(8'd228, 8'h00, 12'd10, 1'b0, acc);        // out of range: drop
        wait_idle();
        checks++; if (nfires !== base) begin errors++; $display("FAIL oor_fire got %0d want 0", nfires - base); end
        checks++; if (train_cnt !== 16'd1) begin errors++; $display("FAIL oor_cnt got %0d want 1", train_cnt); end
        push_rec(8'd6, 8'hAA, 12'd29, 1'b1, acc);          // |sum| == THETA: train
        wait_idle();
        checks++; if (nfires - base !== 1) begin errors++; $display("FAIL conf29_fire got %0d want 1", nfires - base); end
        checks++; if (pos !== 8'd6) begin errors++; $display("FAIL conf29_pos got %0d want 6", pos); end
        checks++;
        if (new_w !== mk_row(9'h1FF, 9'h001, 9'h1FF, 9'h001, 9'h1FF, 9'h001, 9'h1FF, 9'h001)) begin
            errors++; $display("FAIL conf29_w got %h want alternating 001/1ff", new_w);
        end
        checks++; if (train_cnt !== 16'd2) begin errors++; $display("FAIL conf29_cnt got %0d want 2", train_cnt); end
    endtask

    task automatic test_saturation();
        int acc;
        logic [71:0] start;
        start = mk_row(9'h0FF, 9'h100, 9'h0FF, 9'h100, 9'h0FF, 9'h100, 9'h0FF, 9'h100);
        set_row(8'd10, start);
        push_rec(8'd10, 8'hFF, 12'hFFF, 1'b1, acc);        // all up
        wait_idle();
        checks++;
        if (new_w !== mk_row(9'h0FF, 9'h101, 9'h0FF, 9'h101, 9'h0FF, 9'h101, 9'h0FF, 9'h101)) begin
            errors++; $display("FAIL sat_up_w got %h want 0ff/101 pattern", new_w);
        end
        push_rec(8'd10, 8'h00, 12'd5, 1'b0, acc);          // hist==taken: up again
        wait_idle();
        checks++;
        if (new_w !== mk_row(9'h0FF, 9'h102, 9'h0FF, 9'h102, 9'h0FF, 9'h102, 9'h0FF, 9'h102)) begin
            errors++; $display("FAIL sat_up2_w got %h want 0ff/102 pattern", new_w);
        end
        set_row(8'd10, start);
        push_rec(8'd10, 8'hFF, 12'd5, 1'b0, acc);          // all down: floor holds
        wait_idle();
        checks++;
        if (new_w !== mk_row(9'h0FE, 9'h100, 9'h0FE, 9'h100, 9'h0FE, 9'h100, 9'h0FE, 9'h100)) begin
            errors++; $display("FAIL sat_dn_w got %h want 0fe/100 pattern", new_w);
        end
        checks++; if (train_cnt !== 16'd5) begin errors++; $display("FAIL sat_cnt got %0d want 5", train_cnt); end
    endtask

    task automatic test_fifo_full();
        int acc [7];
        int base;
        logic [71:0] exp_w;
        exp_w = mk_row(9'h001, 9'h001, 9'h001, 9'h001, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
        base  = nfires;
        push_rec(8'd19, 8'h0F, 12'hFFB, 1'b1, acc[0]);
        repeat (2) step();
        for (int k = 1; k <= 4; k++) begin
            push_rec(8'(19 + k), 8'h0F, 12'hFFB, 1'b1, acc[k]);
        end
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", res_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b want 1", busy); end
        push_rec(8'd24, 8'h0F, 12'hFFB, 1'b1, acc[5]);
        push_rec(8'd25, 8'h0F, 12'hFFB, 1'b1, acc[6]);
        checks++; if (acc[5] - acc[4] <= 1) begin errors++; $display("FAIL full_hold got %0d want >1", acc[5] - acc[4]); end
        wait_idle();
        checks++; if (nfires - base !== 7) begin errors++; $display("FAIL full_nfire got %0d want 7", nfires - base); end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (fire_pos[base + k] !== 8'(19 + k)) begin
                errors++; $display("FAIL full_order%0d got %0d want %0d", k, fire_pos[base + k], 19 + k);
            end
            checks++;
            if (fire_w[base + k] !== exp_w) begin
                errors++; $display("FAIL full_w%0d got %h want %h", k, fire_w[base + k], exp_w);
            end
        end
        checks++; if (train_cnt !== 16'd12) begin errors++; $display("FAIL full_cnt got %0d want 12", train_cnt); end
    endtask

    task automatic test_back_to_back();
        int a1, a2, base;
        base = nfires;
        push_rec(8'd7, 8'h3C, 12'hFFD, 1'b1, a1);
        push_rec(8'd7, 8'h0F, 12'd100, 1'b0, a2);
        wait_idle();
        checks++; if (nfires - base !== 2) begin errors++; $display("FAIL b2b_nfire got %0d want 2", nfires - base); end
        checks++; if (fire_cyc[base] - a1 !== 11) begin errors++; $display("FAIL b2b_lat got %0d want 11", fire_cyc[base] - a1); end
        checks++;
        if (fire_cyc[base + 1] - fire_cyc[base] !== Spacing) begin
            errors++; $display("FAIL b2b_spacing got %0d want %0d", fire_cyc[base + 1] - fire_cyc[base], Spacing);
        end
        checks++;
        if (fire_w[base] !== mk_row(9'h1FF, 9'h1FF, 9'h001, 9'h001, 9'h001, 9'h001, 9'h1FF, 9'h1FF)) begin
            errors++; $display("FAIL b2b_w1 got %h want first-row pattern", fire_w[base]);
        end
        checks++;
        if (fire_w[base + 1] !== mk_row(9'h1FE, 9'h1FE, 9'h000, 9'h000, 9'h002, 9'h002, 9'h000, 9'h000)) begin
            errors++; $display("FAIL b2b_w2 got %h want second-row pattern", fire_w[base + 1]);
        end
        checks++; if (fire_pos[base + 1] !== 8'd7) begin errors++; $display("FAIL b2b_pos got %0d want 7", fire_pos[base + 1]); end
        checks++; if (train_cnt !== 16'd14) begin errors++; $display("FAIL b2b_cnt got %0d want 14", train_cnt); end
    endtask

    task automatic test_reset_midlane();
        int acc, base;
        base = nfires;
        push_rec(8'd30, 8'h55, 12'd3, 1'b0, acc);
        repeat (5) step();                                 // now in LANE 3
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (fire !== 1'b0) begin errors++; $display("FAIL mid_fire got %b want 0", fire); end
        checks++; if (pos !== 8'd0) begin errors++; $display("FAIL mid_pos got %0d want 0", pos); end
        checks++; if (new_w !== 72'd0) begin errors++; $display("FAIL mid_w got %h want 0", new_w); end
        checks++; if (train_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", train_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rbusy got %b want 0", busy); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", res_ready); end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();
        checks++; if (nfires !== base) begin errors++; $display("FAIL mid_nofire got %0d want 0", nfires - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_confident();
        test_saturation();
        test_fifo_full();
        test_back_to_back();
        test_reset_midlane();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
